// File: rtl/mux_six_to_one_pkg.sv
// Shared op encodings for the six-way operand selector used by the multiplier control path.
`timescale 1ns/1ps
package mux_six_to_one_pkg;

    localparam int unsigned OP_W = 3;

    localparam logic [OP_W-1:0] OP_A = 3'b000;
    localparam logic [OP_W-1:0] OP_B = 3'b001;
    localparam logic [OP_W-1:0] OP_C = 3'b010;
    localparam logic [OP_W-1:0] OP_D = 3'b011;
    localparam logic [OP_W-1:0] OP_E = 3'b100;
    localparam logic [OP_W-1:0] OP_F = 3'b101;

endpackage : mux_six_to_one_pkg

// File: rtl/mux_six_to_one_core.sv
// Combinational six-way select; unused encodings yield zero and raise illegal_c.
`timescale 1ns/1ps
module mux_six_to_one_core
    import mux_six_to_one_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    input  logic [WIDTH-1:0] e,
    input  logic [WIDTH-1:0] f,
    output logic [WIDTH-1:0] sel_c,
    output logic             illegal_c
);

    always_comb begin
        sel_c     = '0;
        illegal_c = 1'b0;
        case (op)
            OP_A:    sel_c = a;
            OP_B:    sel_c = b;
            OP_C:    sel_c = c;
            OP_D:    sel_c = d;
            OP_E:    sel_c = e;
            OP_F:    sel_c = f;
            default: illegal_c = 1'b1;
        endcase
    end

endmodule : mux_six_to_one_core

// File: rtl/mux_six_to_one_sync.sv
// Registered six-input word selector: one-cycle latency, enable-gated capture, error flag on bad ops.
`timescale 1ns/1ps
module mux_six_to_one_sync
    import mux_six_to_one_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             en,
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    input  logic [WIDTH-1:0] e,
    input  logic [WIDTH-1:0] f,
    output logic [WIDTH-1:0] saida,
    output logic             valid,
    output logic             op_err
);

    logic [WIDTH-1:0] sel_c;
    logic             illegal_c;

    logic [WIDTH-1:0] saida_q, saida_d;
    logic             valid_q, valid_d;
    logic             op_err_q, op_err_d;

    mux_six_to_one_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .op        (op),
        .a         (a),
        .b         (b),
        .c         (c),
        .d         (d),
        .e         (e),
        .f         (f),
        .sel_c     (sel_c),
        .illegal_c (illegal_c)
    );

    // Capture only on enabled edges; otherwise everything holds.
    always_comb begin
        saida_d  = saida_q;
        valid_d  = valid_q;
        op_err_d = op_err_q;
        if (en) begin
            saida_d  = sel_c;
            valid_d  = ~illegal_c;
            op_err_d = illegal_c;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            saida_q  <= '0;
            valid_q  <= 1'b0;
            op_err_q <= 1'b0;
        end else begin
            saida_q  <= saida_d;
            valid_q  <= valid_d;
            op_err_q <= op_err_d;
        end
    end

    assign saida  = saida_q;
    assign valid  = valid_q;
    assign op_err = op_err_q;

endmodule : mux_six_to_one_sync

// File: tb/tb_mux_six_to_one_sync.sv
// Directed self-checking bench for mux_six_to_one_sync with hand-computed expectations.
`timescale 1ns/1ps
module tb_mux_six_to_one_sync;

    localparam int unsigned WIDTH = 16;

    logic             clock;
    logic             reset_n;
    logic             en;
    logic [2:0]       op;
    logic [WIDTH-1:0] a, b, c, d, e, f;
    logic [WIDTH-1:0] saida;
    logic             valid;
    logic             op_err;

    int n_checks;
    int n_fail;

    mux_six_to_one_sync #(
        .WIDTH (WIDTH)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .en      (en),
        .op      (op),
        .a       (a),
        .b       (b),
        .c       (c),
        .d       (d),
        .e       (e),
        .f       (f),
        .saida   (saida),
        .valid   (valid),
        .op_err  (op_err)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run still active at %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance past the next rising edge and settle.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check_out(input string tag, input logic [WIDTH-1:0] exp_s,
                             input logic exp_v, input logic exp_e);
        check_eq({tag, ".saida"},  32'(saida),  32'(exp_s));
        check_eq({tag, ".valid"},  32'(valid),  32'(exp_v));
        check_eq({tag, ".op_err"}, 32'(op_err), 32'(exp_e));
    endtask

    logic [WIDTH-1:0] sweep_exp [6];

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset_n  = 1'b0;
        en       = 1'b0;
        op       = 3'b000;
        a = 16'd1; b = 16'd2; c = 16'd3; d = 16'd5; e = 16'd4; f = 16'd6;
        sweep_exp[0] = 16'd1; sweep_exp[1] = 16'd2; sweep_exp[2] = 16'd3;
        sweep_exp[3] = 16'd5; sweep_exp[4] = 16'd4; sweep_exp[5] = 16'd6;

        // Reset state
        step();
        check_out("rst_init", 16'd0, 1'b0, 1'b0);
        reset_n = 1'b1;
        en      = 1'b1;
        op      = 3'b101;
        step();
        check_out("pre_rst", 16'd6, 1'b1, 1'b0);

        // Asynchronous reset mid-cycle, held across an enabled edge
        #3 reset_n = 1'b0;
        #1;
        check_out("async_rst", 16'd0, 1'b0, 1'b0);
        step();
        check_out("rst_hold", 16'd0, 1'b0, 1'b0);
        reset_n = 1'b1;

        // Sweep all legal ops
        for (int i = 0; i < 6; i++) begin
            op = 3'(i);
            step();
            check_out($sformatf("sweep%0d", i), sweep_exp[i], 1'b1, 1'b0);
        end

        // Operand updates
        a = 16'd10; b = 16'd20; c = 16'd30; op = 3'b100;
        step();
        check_out("upd_e", 16'd4, 1'b1, 1'b0);
        e = 16'd12; d = 16'd15; f = 16'd18; op = 3'b101;
        step();
        check_out("upd_f", 16'd18, 1'b1, 1'b0);

        // Illegal ops, then recovery
        b  = 16'd2;
        op = 3'b110;
        step();
        check_out("ill_110", 16'd0, 1'b0, 1'b1);
        op = 3'b111;
        step();
        check_out("ill_111", 16'd0, 1'b0, 1'b1);
        op = 3'b001;
        step();
        check_out("recover_b", 16'd2, 1'b1, 1'b0);

        // Enable hold
        c = 16'd3; op = 3'b010;
        step();
        check_out("hold_pre", 16'd3, 1'b1, 1'b0);
        en = 1'b0; op = 3'b101; f = 16'd6;
        for (int i = 0; i < 3; i++) begin
            step();
            check_out($sformatf("hold%0d", i), 16'd3, 1'b1, 1'b0);
        end
        en = 1'b1;
        step();
        check_out("hold_rel", 16'd6, 1'b1, 1'b0);

        // Enable low also freezes the error flag
        op = 3'b111;
        step();
        check_out("err_set", 16'd0, 1'b0, 1'b1);
        en = 1'b0; op = 3'b000;
        step();
        check_out("err_hold", 16'd0, 1'b0, 1'b1);
        en = 1'b1;

        // Width edge
        f = 16'hFFFF; op = 3'b101;
        step();
        check_out("wide_ones", 16'hFFFF, 1'b1, 1'b0);
        a = 16'h0000; op = 3'b000;
        step();
        check_out("wide_zero", 16'h0000, 1'b1, 1'b0);

        // Pattern distinguishes every bit between operands
        a = 16'hA5C3; d = 16'h5A3C; op = 3'b011;
        step();
        check_out("pattern_d", 16'h5A3C, 1'b1, 1'b0);
        a = 16'h1234; op = 3'b000;
        #2 a = 16'h4321;
        step();
        check_out("sample_edge", 16'h4321, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_mux_six_to_one_sync
